// File: rtl/oserdes_tx_framer_if.sv
// Stream-in / serializer-out bundle for oserdes_tx_framer.
// Clock and reset stay plain module ports; only the datapath signals live here.
interface oserdes_tx_framer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [3:0]        dout;
    logic              t;
    logic              busy;
    logic              underrun;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, dout, t, busy, underrun
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, dout, t, busy, underrun
    );
endinterface

// File: rtl/oserdes_tx_framer.sv
// Framing/gearbox stage feeding a 4:1 DDR output serializer.
// Each burst is sent as: preamble nibbles, data nibbles (LS nibble first), tail nibbles, then high-Z.
//
// state | meaning
// IDLE  | line high-Z, waiting for s_valid
// PRE   | driving preamble; word accepted on the final cycle
// DATA  | shifting out the captured word one nibble per cycle
// FILL  | underrun inside a burst, driving idle nibble
// TAIL  | driving idle nibble before releasing the line
module oserdes_tx_framer #(
    parameter int         WORD_W      = 32,
    parameter int         PREAMBLE_N  = 2,
    parameter logic [3:0] PREAMBLE    = 4'h5,
    parameter logic [3:0] IDLE_NIBBLE = 4'hF,
    parameter int         TAIL_N      = 1
) (
    input logic                c,
    input logic                r_n,
    oserdes_tx_framer_if.slave bus
);
    localparam int NIB_N  = WORD_W / 4;
    localparam int PRE_W  = (PREAMBLE_N > 1) ? $clog2(PREAMBLE_N) : 1;
    localparam int NIB_W  = (NIB_N > 1) ? $clog2(NIB_N) : 1;
    localparam int TAIL_W = (TAIL_N > 1) ? $clog2(TAIL_N) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PREAMBLE_N - 1);
    localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(NIB_N - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_FILL,
        S_TAIL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [NIB_W-1:0]    r_nib_cnt;
    logic [TAIL_W-1:0]   r_tail_cnt;
    logic [WORD_W-1:0]   r_word;
    logic                r_last;

    logic                w_pre_done;
    logic                w_nib_done;
    logic                w_tail_done;
    logic                w_load;
    logic                w_ready;
    logic                w_t;
    logic [3:0]          w_dout;

    assign w_pre_done  = (r_pre_cnt == PRE_LAST);
    assign w_nib_done  = (r_nib_cnt == NIB_LAST);
    assign w_tail_done = (r_tail_cnt == TAIL_LAST);

    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode state only; s_valid steers next state and the load strobe, never s_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_dout      = IDLE_NIBBLE;
        w_t         = 1'b0;
        w_ready     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_t = 1'b1;
                if (bus.s_valid) w_state_nxt = S_PRE;
            end
            S_PRE: begin
                w_dout = PREAMBLE;
                if (w_pre_done) begin
                    w_ready = 1'b1;
                    if (bus.s_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                w_dout = r_word[3:0];
                if (w_nib_done) begin
                    if (r_last) begin
                        w_state_nxt = S_TAIL;
                    end else begin
                        w_ready = 1'b1;
                        if (bus.s_valid) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                w_ready = 1'b1;
                if (bus.s_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_TAIL: begin
                if (w_tail_done) w_state_nxt = S_IDLE;
            end
            default: begin
                w_t         = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            r_pre_cnt  <= '0;
            r_nib_cnt  <= '0;
            r_tail_cnt <= '0;
            r_word     <= '0;
            r_last     <= 1'b0;
        end else begin
            if (r_state == S_PRE && !w_pre_done) begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end else if (w_state_nxt != S_PRE) begin
                r_pre_cnt <= '0;
            end

            if (w_load) begin
                r_word    <= bus.s_data;
                r_last    <= bus.s_last;
                r_nib_cnt <= '0;
            end else if (r_state == S_DATA && !w_nib_done) begin
                r_word    <= r_word >> 4;
                r_nib_cnt <= r_nib_cnt + NIB_W'(1);
            end else begin
                r_nib_cnt <= '0;
            end

            if (r_state == S_TAIL && !w_tail_done) begin
                r_tail_cnt <= r_tail_cnt + TAIL_W'(1);
            end else begin
                r_tail_cnt <= '0;
            end
        end
    end

    assign bus.dout     = w_dout;
    assign bus.t        = w_t;
    assign bus.s_ready  = w_ready;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.underrun = (r_state == S_FILL);
endmodule
